vote_session_ctrl: RTL and testbench
====================================

# vote_session_ctrl

Session sequencer for the voting machine: gates the four candidate buttons so each voter authorisation yields at most one counted vote. Rejects simultaneous presses, issues one-hot increment strobes to the per-candidate vote counters, and drives `valid_vote_casted` to the mode/LED controller. Sits between the button synchronisers and the vote counters.

## Interface
- `HOLD_CYCLES`, 4: cycles `valid_vote_casted` stays high per accepted vote (≥1).
- `LOCKOUT_CYCLES`, 8: minimum cycles after HOLD before the next arm is accepted (≥1).
- `TIMEOUT_CYCLES`, 64: armed-session expiry, used only with `VOTE_TIMEOUT_EN`.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `mode`  in  1  0 = voting, 1 = result display; voting is suspended while 1.
- `voter_arm`  in  1  officer authorisation; level, sampled only in IDLE.
- `candidate1_button` … `candidate4_button`  in  1 each  synchronised button levels.
- `candidate_inc`  out  4  one-cycle, one-hot increment strobe; bit i-1 = candidate i.
- `valid_vote_casted`  out  1  vote-accepted indication.
- `armed`  out  1  high in ARMED.
- `busy`  out  1  high in CAST, HOLD, LOCKOUT.
- `reject_count`  out  8  saturating count of rejected multi-press events.

## Operation
- All outputs registered. Reset: state IDLE, all outputs 0, `reject_count`=0, button history register=0, all timers 0.
- Edge detect: `rise[i] = btn[i] & ~prev[i]`; `prev` updates every cycle in every state.
- IDLE: if `voter_arm` & `mode`=0, go to ARMED. `voter_arm` ignored when `mode`=1.
- ARMED:
  - `mode`=1 → IDLE; vote cancelled, no strobe.
  - Any `rise` with exactly one button currently high → CAST for that candidate.
  - Any `rise` with ≥2 buttons high → stay ARMED, `reject_count` += 1, saturating at 255.
  - Buttons already held on entry produce no rise and are ignored until released and re-pressed.
- CAST: exactly one cycle; `candidate_inc` one-hot, `valid_vote_casted`=1. Then HOLD, or LOCKOUT directly if `HOLD_CYCLES`=1.
- HOLD: `valid_vote_casted`=1 for a further `HOLD_CYCLES`-1 cycles, then LOCKOUT.
- LOCKOUT: outputs low except `busy`. Exit to IDLE once `LOCKOUT_CYCLES` cycles have elapsed and all buttons are low; stays while any button is held.
- `mode` changes during CAST, HOLD or LOCKOUT are ignored; a counted vote is never withdrawn.
- `candidate_inc` is never asserted outside CAST; at most one strobe per arm.
- Timers are `$clog2(max param)+1` bits, down-counting, loaded on state entry.

## Timing
- `voter_arm` high at edge t while in IDLE → `armed`=1 from t+1.
- Qualifying rise sampled at edge t → `candidate_inc` and `valid_vote_casted` high in cycle t+1 (`armed` low from t+1).
- `valid_vote_casted` high for exactly `HOLD_CYCLES` consecutive cycles starting t+1.
- `busy` high from t+1 through the last LOCKOUT cycle; earliest re-arm sample is at t+1+`HOLD_CYCLES`+`LOCKOUT_CYCLES`.
- `reject_count` updates the cycle after the rejected sample.
- Reset asserted in any state → outputs 0 at the next edge; an in-flight strobe is suppressed.

## Configuration
- `VOTE_TIMEOUT_EN` defined: ARMED carries a timer loaded with `TIMEOUT_CYCLES` on entry. It expires after `TIMEOUT_CYCLES` cycles with no accepted vote → IDLE, no strobe. A qualifying rise in the expiry cycle wins (CAST).
- Not defined: ARMED waits indefinitely; `TIMEOUT_CYCLES` unused; no timer logic.

## Test plan
- Reset, arm, press `candidate2_button` → `candidate_inc`=4'b0010 for 1 cycle, `valid_vote_casted` high 4 cycles, `busy` high 12 cycles, then IDLE.
- Armed, buttons 1 and 3 rise together → no strobe, `reject_count`=1, still ARMED; then press button 3 alone → `candidate_inc`=4'b0100.
- Armed, `mode`→1 before any press → IDLE, `candidate_inc` stays 0, `armed` low next cycle.
- Button 4 held through LOCKOUT for 20 cycles → IDLE entered only after release; re-arm with button still held, no rise → no strobe.
- 256 rejected double presses → `reject_count` saturates at 255.
- With `VOTE_TIMEOUT_EN`: arm, no press for 64 cycles → IDLE, no strobe; without the macro → still ARMED at cycle 200.

Source files
------------

// File: rtl/vote_session_ctrl_if.sv
// Voting session bus: button/mode/arm inputs and the vote strobe/status outputs.
interface vote_session_ctrl_if;
  logic       mode;
  logic       voter_arm;
  logic       candidate1_button;
  logic       candidate2_button;
  logic       candidate3_button;
  logic       candidate4_button;
  logic [3:0] candidate_inc;
  logic       valid_vote_casted;
  logic       armed;
  logic       busy;
  logic [7:0] reject_count;

  modport master (
    output mode, voter_arm,
    output candidate1_button, candidate2_button, candidate3_button, candidate4_button,
    input  candidate_inc, valid_vote_casted, armed, busy, reject_count
  );

  modport slave (
    input  mode, voter_arm,
    input  candidate1_button, candidate2_button, candidate3_button, candidate4_button,
    output candidate_inc, valid_vote_casted, armed, busy, reject_count
  );
endinterface

// File: rtl/vote_session_ctrl.sv
// Voter session sequencer: one counted vote per authorisation, multi-press rejection.
// Optional VOTE_TIMEOUT_EN: armed sessions expire after TIMEOUT_CYCLES.
module vote_session_ctrl #(
  parameter int HOLD_CYCLES    = 4,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clock,
  input  logic               reset,
  vote_session_ctrl_if.slave bus
);

  localparam int MAXHL = (HOLD_CYCLES > LOCKOUT_CYCLES) ? HOLD_CYCLES : LOCKOUT_CYCLES;
  localparam int MAXP  = (MAXHL > TIMEOUT_CYCLES) ? MAXHL : TIMEOUT_CYCLES;
  localparam int TW    = $clog2(MAXP) + 1;

  typedef enum logic [2:0] {IDLE, ARMED, CAST, HOLD, LOCKOUT} state_t;

  state_t          state, nxt;
  logic [TW-1:0]   tmr, tmr_d;
  logic [3:0]      btn, prev, rise;
  logic            one_hot, multi, rej_inc;
  logic [3:0]      inc_q;
  logic            vvc_q, armed_q, busy_q;
  logic [7:0]      rej_q;

  assign btn     = {bus.candidate4_button, bus.candidate3_button,
                    bus.candidate2_button, bus.candidate1_button};
  assign rise    = btn & ~prev;
  assign one_hot = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
  assign multi   = (btn != 4'd0) && !one_hot;

  always_comb begin
    nxt     = state;
    tmr_d   = tmr;
    rej_inc = 1'b0;
    case (state)
      IDLE: if (bus.voter_arm && !bus.mode) begin
        nxt = ARMED;
`ifdef VOTE_TIMEOUT_EN
        tmr_d = TW'(TIMEOUT_CYCLES);
`endif
      end
      ARMED: begin
        if (bus.mode) nxt = IDLE;
        else if ((rise != 4'd0) && one_hot) nxt = CAST;
        else begin
          rej_inc = (rise != 4'd0) && multi;
`ifdef VOTE_TIMEOUT_EN
          if (tmr <= TW'(1)) nxt = IDLE;
          else tmr_d = tmr - TW'(1);
`endif
        end
      end
      CAST: begin
        if (HOLD_CYCLES == 1) begin
          nxt   = LOCKOUT;
          tmr_d = TW'(LOCKOUT_CYCLES);
        end else begin
          nxt   = HOLD;
          tmr_d = TW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (tmr <= TW'(1)) begin
          nxt   = LOCKOUT;
          tmr_d = TW'(LOCKOUT_CYCLES);
        end else tmr_d = tmr - TW'(1);
      end
      LOCKOUT: begin
        // timer parks at 1 once elapsed; exit waits for every button released
        if (tmr > TW'(1)) tmr_d = tmr - TW'(1);
        else if (btn == 4'd0) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      tmr     <= '0;
      prev    <= '0;
      inc_q   <= '0;
      vvc_q   <= 1'b0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      rej_q   <= '0;
    end else begin
      state   <= nxt;
      tmr     <= tmr_d;
      prev    <= btn;
      inc_q   <= (nxt == CAST) ? btn : 4'd0;
      vvc_q   <= (nxt == CAST) || (nxt == HOLD);
      armed_q <= (nxt == ARMED);
      busy_q  <= (nxt == CAST) || (nxt == HOLD) || (nxt == LOCKOUT);
      if (rej_inc && (rej_q != 8'hFF)) rej_q <= rej_q + 8'd1;
    end
  end

  assign bus.candidate_inc     = inc_q;
  assign bus.valid_vote_casted = vvc_q;
  assign bus.armed             = armed_q;
  assign bus.busy              = busy_q;
  assign bus.reject_count      = rej_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Randomized + directed bench for vote_session_ctrl against a phase/age reference model.
module tb_vote_session_ctrl;
  localparam int H  = 4;
  localparam int L  = 8;
  localparam int TO = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vote_session_ctrl_if vif();

  vote_session_ctrl #(.HOLD_CYCLES(H), .LOCKOUT_CYCLES(L), .TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (vif.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // model: phase 0 idle, 1 armed, 2 vote in progress; age counts cycles in phase
  int         m_phase = 0;
  int         m_age   = 0;
  logic [3:0] m_prev  = '0;
  logic [3:0] e_inc   = '0;
  logic       e_vvc = 1'b0, e_armed = 1'b0, e_busy = 1'b0;
  int         e_rej = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic set_btn(logic [3:0] b);
    vif.candidate1_button = b[0];
    vif.candidate2_button = b[1];
    vif.candidate3_button = b[2];
    vif.candidate4_button = b[3];
  endtask

  function automatic logic [3:0] cur_btn();
    return {vif.candidate4_button, vif.candidate3_button,
            vif.candidate2_button, vif.candidate1_button};
  endfunction

  task automatic model_step();
    logic [3:0] b, r;
    int nh;
    b  = cur_btn();
    r  = b & ~m_prev;
    nh = $countones(b);
    e_inc = '0;
    if (reset) begin
      m_phase = 0; m_age = 0; e_rej = 0; b = '0;
    end else begin
      case (m_phase)
        0: if (vif.voter_arm && !vif.mode) begin m_phase = 1; m_age = 0; end
        1: begin
          if (vif.mode) m_phase = 0;
          else if (r != 0 && nh == 1) begin m_phase = 2; m_age = 0; e_inc = b; end
          else begin
            if (r != 0 && nh >= 2 && e_rej < 255) e_rej++;
`ifdef VOTE_TIMEOUT_EN
            m_age++;
            if (m_age >= TO) m_phase = 0;
`endif
          end
        end
        default: begin
          m_age++;
          if (m_age >= H + L && b == 0) m_phase = 0;
        end
      endcase
    end
    m_prev  = b;
    e_armed = (m_phase == 1);
    e_busy  = (m_phase == 2);
    e_vvc   = (m_phase == 2) && (m_age < H);
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    check("candidate_inc", {28'd0, vif.candidate_inc}, {28'd0, e_inc});
    check("valid_vote_casted", {31'd0, vif.valid_vote_casted}, {31'd0, e_vvc});
    check("armed", {31'd0, vif.armed}, {31'd0, e_armed});
    check("busy", {31'd0, vif.busy}, {31'd0, e_busy});
    check("reject_count", {24'd0, vif.reject_count}, e_rej);
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  initial begin
    int vc, bc;
    vif.mode = 1'b0; vif.voter_arm = 1'b0; set_btn(4'd0);
    #2;
    do_reset();
    check("reset_inc", {28'd0, vif.candidate_inc}, 32'd0);
    check("reset_rej", {24'd0, vif.reject_count}, 32'd0);

    // single vote for candidate 2
    vif.voter_arm = 1'b1; step();
    check("arm", {31'd0, vif.armed}, 32'd1);
    vif.voter_arm = 1'b0; set_btn(4'b0010); step();
    check("c2_inc", {28'd0, vif.candidate_inc}, 32'h2);
    vc = int'(vif.valid_vote_casted); bc = int'(vif.busy);
    set_btn(4'd0);
    for (int i = 0; i < 19; i++) begin
      step(); vc += int'(vif.valid_vote_casted); bc += int'(vif.busy);
    end
    check("vvc_len", vc, 32'd4);
    check("busy_len", bc, 32'd12);

    // simultaneous 1+3 rejected, then 3 alone accepted
    vif.voter_arm = 1'b1; step(); vif.voter_arm = 1'b0;
    set_btn(4'b0101); step();
    check("dbl_inc", {28'd0, vif.candidate_inc}, 32'd0);
    check("dbl_rej", {24'd0, vif.reject_count}, 32'd1);
    check("dbl_armed", {31'd0, vif.armed}, 32'd1);
    set_btn(4'd0); step();
    set_btn(4'b0100); step();
    check("c3_inc", {28'd0, vif.candidate_inc}, 32'h4);
    set_btn(4'd0);
    for (int i = 0; i < 14; i++) step();

    // cancel via mode
    vif.voter_arm = 1'b1; step(); vif.voter_arm = 1'b0;
    vif.mode = 1'b1; step();
    check("cancel_armed", {31'd0, vif.armed}, 32'd0);
    check("cancel_inc", {28'd0, vif.candidate_inc}, 32'd0);
    vif.mode = 1'b0; step();

    // button 4 held through lockout
    vif.voter_arm = 1'b1; step(); vif.voter_arm = 1'b0;
    set_btn(4'b1000); step();
    check("c4_inc", {28'd0, vif.candidate_inc}, 32'h8);
    for (int i = 0; i < 20; i++) step();
    check("held_busy", {31'd0, vif.busy}, 32'd1);
    set_btn(4'd0); step();
    check("release_busy", {31'd0, vif.busy}, 32'd0);
    set_btn(4'b1000); step();
    vif.voter_arm = 1'b1; step(); vif.voter_arm = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("held_noinc", {28'd0, vif.candidate_inc}, 32'd0);
    check("held_armed", {31'd0, vif.armed}, 32'd1);
    set_btn(4'd0); vif.mode = 1'b1; step(); vif.mode = 1'b0; step();

    // armed with no press
    vif.voter_arm = 1'b1; step(); vif.voter_arm = 1'b0;
    for (int i = 0; i < 200; i++) step();
`ifdef VOTE_TIMEOUT_EN
    check("timeout_armed", {31'd0, vif.armed}, 32'd0);
`else
    check("wait_armed", {31'd0, vif.armed}, 32'd1);
`endif
    vif.mode = 1'b1; step(); vif.mode = 1'b0;

    // reject counter saturation
    do_reset();
    vif.voter_arm = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_btn(4'b0011); step();
      set_btn(4'd0); step();
    end
    check("rej_sat", {24'd0, vif.reject_count}, 32'd255);
    vif.voter_arm = 1'b0; vif.mode = 1'b1; step(); vif.mode = 1'b0;

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] b;
      b = cur_btn();
      for (int k = 0; k < 4; k++) if ($urandom_range(5) == 0) b[k] = ~b[k];
      set_btn(b);
      if ($urandom_range(40) == 0) vif.mode = ~vif.mode;
      vif.voter_arm = ($urandom_range(3) == 0);
      reset = ($urandom_range(600) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
